// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle signed shift-add multiplier / restoring divider
module muldiv_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state, state_nx;
  logic               op_r;
  logic [WIDTH-1:0]   a_r, b_r;
  // MPY: |multiplicand|; DIV: |divisor|
  logic [WIDTH-1:0]   mag;
  logic               sign_p, sign_r;
  logic [CW-1:0]      cnt;
  // MPY: running product hi:multiplier; DIV: remainder:quotient
  logic [2*WIDTH-1:0] acc;

  logic               last_iter, b_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mpy_sum, div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign b_zero    = (b_r == '0);
  // The most negative value negates to itself, which read unsigned is its magnitude
  assign abs_a     = a_r[WIDTH-1] ? -a_r : a_r;
  assign abs_b     = b_r[WIDTH-1] ? -b_r : b_r;
  assign mpy_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag};
  assign div_trial = {1'b0, acc[2*WIDTH-2:WIDTH-1]} - {1'b0, mag};
  assign prod_fix  = sign_p ? -acc : acc;
  assign quo_fix   = sign_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix   = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; divide-by-zero skips the iteration entirely
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = (op_r && b_zero) ? S_DONE : S_RUN;
      S_RUN:   if (last_iter) state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath, result registers and registered busy/done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      res_hi   <= '0;
      res_lo   <= '0;
      op_r     <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      mag      <= '0;
      sign_p   <= 1'b0;
      sign_r   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
    end else begin
      busy <= (state_nx == S_LOAD) || (state_nx == S_RUN) || (state_nx == S_FIX);
      done <= (state_nx == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r     <= op;
            a_r      <= a;
            b_r      <= b;
            div_zero <= 1'b0;
          end
        end
        S_LOAD: begin
          sign_p <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
          sign_r <= a_r[WIDTH-1];
          cnt    <= '0;
          if (op_r) begin
            mag <= abs_b;
            acc <= {{WIDTH{1'b0}}, abs_a};
          end else begin
            mag <= abs_a;
            acc <= {{WIDTH{1'b0}}, abs_b};
          end
          if (op_r && b_zero) begin
            res_hi   <= a_r;
            res_lo   <= '1;
            div_zero <= 1'b1;
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (!op_r) begin
            // Add multiplicand into the high half when the multiplier LSB is set, then shift right
            acc <= acc[0] ? {mpy_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
          end else begin
            // Borrow out of the trial subtract means restore (keep the shifted value)
            acc <= div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                    : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          end
        end
        S_FIX: begin
          if (op_r) begin
            res_hi <= rem_fix;
            res_lo <= quo_fix;
          end else begin
            {res_hi, res_lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq against an arithmetic model
module tb_muldiv_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] res_hi, res_lo;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed arithmetic on plain integers
  task automatic model(input logic o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    longint sa, sb, p, q, r;
    logic [63:0] pv;
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    dz = 1'b0;
    if (!o) begin
      p  = sa * sb;
      pv = p;
      hi = pv[2*W-1:W];
      lo = pv[W-1:0];
    end else if (sb == 0) begin
      hi = aa;
      lo = '1;
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      pv = q;
      lo = pv[W-1:0];
      pv = r;
      hi = pv[W-1:0];
    end
  endtask

  // Issue one op and follow it to completion, checking timing, stability and results
  task automatic do_op(input string tag, input logic o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input bit inject);
    logic [W-1:0] ehi, elo, phi, plo;
    logic edz, dz1;
    int exp_done, done_cyc, busy_err, stab_err;
    model(o, aa, bb, ehi, elo, edz);
    exp_done = (o && bb == '0) ? 2 : W + 3;
    phi = res_hi;
    plo = res_lo;
    op = o; a = aa; b = bb; start = 1'b1;
    done_cyc = -1; busy_err = 0; stab_err = 0; dz1 = 1'bx;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      start = 1'b0;
      if (inject && (cyc == 5 || cyc == W + 3)) begin
        start = 1'b1;
        op = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end
      if (cyc == 1) dz1 = div_zero;
      if (busy !== (cyc < exp_done)) busy_err++;
      if (cyc < exp_done && (res_hi !== phi || res_lo !== plo)) stab_err++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    chk({tag, " done_cycle"}, done_cyc, exp_done);
    chk({tag, " busy_profile_errs"}, busy_err, 0);
    chk({tag, " early_change_errs"}, stab_err, 0);
    chk({tag, " res_hi"}, res_hi, ehi);
    chk({tag, " res_lo"}, res_lo, elo);
    chk({tag, " div_zero"}, div_zero, edz);
    chk({tag, " div_zero_clr_at_start"}, dz1, 1'b0);
    tick();
    start = 1'b0;
    chk({tag, " done_one_pulse"}, done, 1'b0);
    chk({tag, " idle_after_done"}, busy, 1'b0);
  endtask

  initial begin
    int saw_done;
    logic o;
    logic [W-1:0] ra, rb;

    tick();
    tick();
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset div_zero", div_zero, 1'b0);
    chk("reset res_hi", res_hi, 0);
    chk("reset res_lo", res_lo, 0);
    rst_n = 1'b1;
    tick();

    do_op("mpy 3x-5", 1'b0, 16'd3, 16'hFFFB, 1'b0);
    do_op("div -7/2", 1'b1, 16'hFFF9, 16'd2, 1'b0);
    do_op("div 100/7", 1'b1, 16'd100, 16'd7, 1'b0);
    do_op("div 100/0", 1'b1, 16'd100, 16'd0, 1'b0);
    do_op("div after dz", 1'b1, 16'd9, 16'hFFFD, 1'b0);
    do_op("div ovf", 1'b1, 16'h8000, 16'hFFFF, 1'b0);
    do_op("mpy min*min", 1'b0, 16'h8000, 16'h8000, 1'b0);
    do_op("mpy ignore start", 1'b0, 16'h1234, 16'hFF00, 1'b1);
    do_op("div ignore start", 1'b1, 16'h8001, 16'd300, 1'b1);

    for (int i = 0; i < 16; i++) begin
      o  = 1'($urandom);
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      do_op("random", o, ra, rb, 1'b0);
    end

    // Reset mid-operation
    op = 1'b0; a = 16'h00FF; b = 16'h0101; start = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst div_zero", div_zero, 1'b0);
    chk("midrst res_hi", res_hi, 0);
    chk("midrst res_lo", res_lo, 0);
    tick();
    tick();
    rst_n = 1'b1;
    saw_done = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) saw_done++;
    end
    chk("midrst no_done_or_busy", saw_done, 0);
    do_op("mpy 7x6 after rst", 1'b0, 16'd7, 16'd6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
